// File: rtl/mac_product_accumulator.sv
// Accumulates a stream of unnormalized {sign, exp, mant} products into one
// dot-product group sum and emits it saturated to OUT_W over a valid/ready port.
module mac_product_accumulator #(
  parameter int MAX_LEN = 256,
  parameter int ACC_W   = 40,
  parameter int OUT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             i_sign,
  input  logic [3:0]       i_exp,
  input  logic [17:0]      i_mant,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_sat,
  output logic             o_len_err
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {IDLE, ACC} state_t;

  state_t                  state_reg, state_next;
  logic signed [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic signed [ACC_W-1:0] term_mag, term, sum;
  logic                    accept, closing;
  logic                    sat_hi, sat_lo;
  logic [OUT_W-1:0]        sat_data;

  // Aligned term; the mantissa is zero-extended before shifting so no bits are lost.
  assign term_mag = ACC_W'(i_mant) << i_exp;
  assign term     = i_sign ? -term_mag : term_mag;
  assign sum      = ((state_reg == ACC) ? acc_reg : '0) + term;
  assign closing  = i_last | (cnt_reg == CNT_W'(MAX_LEN - 1));

  assign sat_hi   = (sum > SAT_HI);
  assign sat_lo   = (sum < SAT_LO);
  assign sat_data = sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                    sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} : sum[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    if (accept) begin
      if (closing) begin
        state_next = IDLE;
        acc_next   = '0;
        cnt_next   = '0;
      end else begin
        state_next = ACC;
        acc_next   = sum;
        cnt_next   = cnt_reg + CNT_W'(1);
      end
    end
  end

  // A pending result blocks input only while downstream is stalling it.
  always_comb begin
    i_ready = ~(o_valid & ~o_ready);
    accept  = i_valid & i_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_sat     <= 1'b0;
      o_len_err <= 1'b0;
    end else if (accept && closing) begin
      o_valid   <= 1'b1;
      o_data    <= sat_data;
      o_sat     <= sat_hi | sat_lo;
      o_len_err <= ~i_last;
    end else if (o_valid && o_ready) begin
      o_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_product_accumulator.sv
// Directed bench for mac_product_accumulator: single-beat vector table plus
// multi-beat, back-pressure, length-limit and reset sequences.
module tb_mac_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_ready, i_sign, i_last;
  logic [3:0]  i_exp;
  logic [17:0] i_mant;
  logic        o_valid, o_ready, o_sat, o_len_err;
  logic [31:0] o_data;

  int checks = 0;
  int errors = 0;

  mac_product_accumulator #(.MAX_LEN(4), .ACC_W(40), .OUT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_sign(i_sign), .i_exp(i_exp),
    .i_mant(i_mant), .i_last(i_last),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_sat(o_sat), .o_len_err(o_len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [3:0]  e;
    logic [17:0] m;
    logic [31:0] d;
    logic        sat;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("check %s ok value=%h", name, act);
    end
  endtask

  task automatic send_beat(input logic s, input logic [3:0] e, input logic [17:0] m, input logic l);
    int waited = 0;
    i_valid = 1'b1; i_sign = s; i_exp = e; i_mant = m; i_last = l;
    while (!i_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!i_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_wait actual=i_ready_low required=i_ready_high");
    end
    tick();
    $display("beat sign=%0d exp=%0d mant=%0d last=%0d", s, e, m, l);
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic chk_result(input string name, input logic [31:0] d, input logic sat, input logic len);
    chk({name, "_valid"}, 32'(o_valid), 32'd1);
    chk({name, "_data"}, o_data, d);
    chk({name, "_sat"}, 32'(o_sat), 32'(sat));
    chk({name, "_len_err"}, 32'(o_len_err), 32'(len));
  endtask

  task automatic drain(input string name);
    o_ready = 1'b1;
    tick();
    chk({name, "_drained"}, 32'(o_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'd3,  18'd5,     32'd40,        1'b0};
    vecs[1] = '{1'b1, 4'd3,  18'd5,     32'hFFFF_FFD8, 1'b0};
    vecs[2] = '{1'b0, 4'd0,  18'd0,     32'd0,         1'b0};
    vecs[3] = '{1'b1, 4'd0,  18'd0,     32'd0,         1'b0};
    vecs[4] = '{1'b0, 4'd14, 18'd65025, 32'h3F80_4000, 1'b0};
    vecs[5] = '{1'b1, 4'd14, 18'd65025, 32'hC07F_C000, 1'b0};
    vecs[6] = '{1'b0, 4'd0,  18'd65025, 32'h0000_FE01, 1'b0};

    rst_n = 1'b0; i_valid = 1'b0; i_sign = 1'b0; i_exp = '0; i_mant = '0;
    i_last = 1'b0; o_ready = 1'b1;
    tick();
    tick();
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data", o_data, 32'd0);
    chk("rst_o_sat", 32'(o_sat), 32'd0);
    chk("rst_o_len_err", 32'(o_len_err), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_i_ready", 32'(i_ready), 32'd1);

    // Single-beat groups: result one cycle after acceptance.
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("vec%0d_pre_valid", i), 32'(o_valid), 32'd0);
      send_beat(vecs[i].s, vecs[i].e, vecs[i].m, 1'b1);
      chk_result($sformatf("vec%0d", i), vecs[i].d, vecs[i].sat, 1'b0);
      drain($sformatf("vec%0d", i));
    end

    // Mixed-sign group: 100 - 100 + 7.
    send_beat(1'b0, 4'd0, 18'd100, 1'b0);
    chk("mix_mid_valid", 32'(o_valid), 32'd0);
    send_beat(1'b1, 4'd2, 18'd25, 1'b0);
    send_beat(1'b0, 4'd0, 18'd7, 1'b1);
    chk_result("mix", 32'd7, 1'b0, 1'b0);
    drain("mix");

    // Saturation, positive and negative, plus exact negative limit.
    for (int k = 0; k < 3; k++) send_beat(1'b0, 4'd14, 18'd65025, k == 2);
    chk_result("satpos", 32'h7FFF_FFFF, 1'b1, 1'b0);
    drain("satpos");
    for (int k = 0; k < 3; k++) send_beat(1'b1, 4'd14, 18'd65025, k == 2);
    chk_result("satneg", 32'h8000_0000, 1'b1, 1'b0);
    drain("satneg");
    send_beat(1'b1, 4'd14, 18'd65025, 1'b0);
    send_beat(1'b1, 4'd14, 18'd65025, 1'b0);
    send_beat(1'b1, 4'd14, 18'd1022, 1'b1);
    chk_result("minexact", 32'h8000_0000, 1'b0, 1'b0);
    drain("minexact");
    send_beat(1'b0, 4'd14, 18'd65025, 1'b0);
    send_beat(1'b0, 4'd14, 18'd65025, 1'b0);
    send_beat(1'b0, 4'd14, 18'd1022, 1'b1);
    chk_result("maxover", 32'h7FFF_FFFF, 1'b1, 1'b0);
    drain("maxover");

    // Back-pressure: result held, next beat waits, then transfer and accept together.
    o_ready = 1'b0;
    send_beat(1'b0, 4'd0, 18'd5, 1'b1);
    chk_result("bp", 32'd5, 1'b0, 1'b0);
    i_valid = 1'b1; i_sign = 1'b0; i_exp = 4'd0; i_mant = 18'd9; i_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_stall%0d_i_ready", c), 32'(i_ready), 32'd0);
      chk($sformatf("bp_stall%0d_data", c), o_data, 32'd5);
      tick();
    end
    o_ready = 1'b1;
    #1;
    chk("bp_release_i_ready", 32'(i_ready), 32'd1);
    tick();
    i_valid = 1'b0; i_last = 1'b0;
    chk_result("bp_next", 32'd9, 1'b0, 1'b0);
    chk("bp_after_i_ready", 32'(i_ready), 32'd1);
    drain("bp_next");

    // Length limit (MAX_LEN=4): fourth beat closes the group with len_err.
    for (int k = 0; k < 4; k++) send_beat(1'b0, 4'd0, 18'd1, 1'b0);
    chk_result("maxlen", 32'd4, 1'b0, 1'b1);
    send_beat(1'b0, 4'd0, 18'd2, 1'b1);
    chk_result("maxlen_fresh", 32'd2, 1'b0, 1'b0);
    drain("maxlen_fresh");

    // Reset mid-group discards the partial sum.
    send_beat(1'b0, 4'd0, 18'd50, 1'b0);
    send_beat(1'b0, 4'd0, 18'd50, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rstmid_valid", 32'(o_valid), 32'd0);
    send_beat(1'b0, 4'd0, 18'd9, 1'b1);
    chk_result("rstmid", 32'd9, 1'b0, 1'b0);
    drain("rstmid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
